id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register for the RV32 core, sitting directly downstream of the main control decoder. Each cycle it captures the decoded control bundle (branch, memRead, memtoReg, ALUOp, memWrite, ALUSrc, regWrite) together with the operands and register indices, and presents them to the execute stage.

- It detects load-use hazards against the instruction already in EX and inserts a one-cycle bubble.
- It honours a downstream stall and a branch-resolution flush.
- It keeps a saturating count of inserted hazard bubbles.

## Interface
Parameters:
- XLEN, 32, datapath width
- RA_W, 5, register-index width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  PC, register-file reads, sign-extended immediate
- id_rs1, id_rs2, id_rd  in  RA_W each  register indices
- id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads rs1/rs2 (0 for LUI/AUIPC/JAL etc.)
- id_funct3  in  3 ; id_funct7_5  in  1  ALU-control qualifiers
- id_branch, id_memRead, id_memtoReg, id_memWrite, id_ALUSrc, id_regWrite  in  1 each ; id_ALUOp  in  2  decoder outputs
- ex_stall  in  1  EX/MEM cannot accept new work; hold
- ex_flush  in  1  taken branch/jump resolved in EX; kill incoming instruction
- stall_id  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1 ; ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN ; ex_rs1, ex_rs2, ex_rd  out  RA_W ; ex_funct3  out  3 ; ex_funct7_5  out  1
- ex_branch, ex_memRead, ex_memtoReg, ex_memWrite, ex_ALUSrc, ex_regWrite  out  1 ; ex_ALUOp  out  2
- bubble_count  out  16  hazard bubbles inserted, saturating

## Operation
Hazard term (combinational, from registered EX state and current id_* inputs):
- hazard = id_valid & ex_valid & ex_memRead & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd))

Stall output:
- stall_id = !ex_flush & (hazard | ex_stall)

Per-edge action, in priority order:
1. **rst**: ex_valid=0; all ex_* data, index and control outputs=0; bubble_count=0.
2. **ex_flush**: ex_valid=0 and all ex control outputs=0. Data fields are don't-care and may be loaded or held. Flush overrides ex_stall and hazard.
3. **ex_stall**: every ex_* output holds its value.
4. **hazard**: insert a bubble: ex_valid=0, controls=0. bubble_count increments by 1, saturating at 16'hFFFF. The upstream stage holds the ID instruction because stall_id=1.
5. **Otherwise**: capture all id_* fields. ex_valid=id_valid. Control outputs equal id_* controls if id_valid=1, else 0.

Invariants and boundary behaviour:
- Invariant: ex_valid=0 implies every ex control output is 0. No store, register write or branch escapes from a bubble.
- A single load-use hazard costs exactly one bubble. After the bubble, ex_memRead=0, so the hazard clears and the held instruction advances on the next edge.
- ex_rd=0 never causes a hazard.
- bubble_count increments only on hazard bubbles. It does not increment on flushes, on stalls, or while id_valid=0.

## Timing
- Latency ID→EX: 1 cycle. No combinational path from id_* to ex_* outputs.
- stall_id is combinational, valid in the same cycle as the inputs.
- All outputs are 0 in the cycle after any rst edge. Reset asserted mid-stall or mid-hazard still clears everything on that edge.
- Simultaneous ex_stall and hazard: hold takes priority. The hazard is re-evaluated after the stall releases, and bubble_count is unchanged while held.

## Test plan
1. **Reset**: rst=1 for 2 cycles with id_valid=1, id_regWrite=1 → ex_valid=0, ex_regWrite=0, bubble_count=0, all data 0.
2. **Pass-through**: R-type add with rd=5, rs1=1, rs2=2, ALUOp=2'b10, regWrite=1, rs1_data=32'h11 → next edge: ex_valid=1, ex_rd=5, ex_ALUOp=2'b10, ex_rs1_data=32'h11, stall_id=0 throughout.
3. **Load-use**: lw x5 (memRead=1, rd=5), then add x6,x5,x7 →
   - while lw is in EX: stall_id=1.
   - next edge: ex_valid=0, ex_memRead=0, bubble_count=1.
   - following edge: add captured, ex_rd=6.
4. **No false hazard**:
   - lw x0, then instruction with rs1=0 → no stall.
   - lw x5, then LUI with id_rs1 field=5 and id_uses_rs1=0 → no stall, bubble_count unchanged.
5. **Flush vs hazard**: load-use condition present with ex_flush=1 in the same cycle → stall_id=0; next edge ex_valid=0, all controls 0, bubble_count unchanged.
6. **Downstream stall**: ex_stall=1 for 3 cycles with a store in EX → ex_* held (ex_memWrite=1) and stall_id=1 each cycle; after release, the next ID instruction is captured.

Source files
------------

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with load-use bubble insertion,
//               downstream stall hold, branch flush and bubble counter.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7_5,
    input  logic            id_branch,
    input  logic            id_memRead,
    input  logic            id_memtoReg,
    input  logic            id_memWrite,
    input  logic            id_ALUSrc,
    input  logic            id_regWrite,
    input  logic [1:0]      id_ALUOp,
    input  logic            ex_stall,
    input  logic            ex_flush,
    output logic            stall_id,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [RA_W-1:0] ex_rs1,
    output logic [RA_W-1:0] ex_rs2,
    output logic [RA_W-1:0] ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7_5,
    output logic            ex_branch,
    output logic            ex_memRead,
    output logic            ex_memtoReg,
    output logic            ex_memWrite,
    output logic            ex_ALUSrc,
    output logic            ex_regWrite,
    output logic [1:0]      ex_ALUOp,
    output logic [15:0]     bubble_count
);

    localparam logic [15:0] c_BUBBLE_MAX = 16'hFFFF;

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       memto_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [2:0]      funct3;
        logic            funct7_5;
        ctrl_t           ctrl;
    } ex_t;

    ex_t         r_ex_q;
    ex_t         w_ex_d;
    logic [15:0] r_bubble_cnt_q;
    logic [15:0] w_bubble_cnt_d;
    logic        w_hazard;
    ctrl_t       w_id_ctrl;

    assign w_id_ctrl = '{branch:    id_branch,
                         mem_read:  id_memRead,
                         memto_reg: id_memtoReg,
                         mem_write: id_memWrite,
                         alu_src:   id_ALUSrc,
                         reg_write: id_regWrite,
                         alu_op:    id_ALUOp};

    // A load in EX whose destination is read by the ID instruction; x0 never hazards.
    assign w_hazard = id_valid & r_ex_q.valid & r_ex_q.ctrl.mem_read &
                      (r_ex_q.rd != '0) &
                      ((id_uses_rs1 & (id_rs1 == r_ex_q.rd)) |
                       (id_uses_rs2 & (id_rs2 == r_ex_q.rd)));

    assign stall_id = ~ex_flush & (w_hazard | ex_stall);

    always_comb begin
        w_ex_d         = r_ex_q;
        w_bubble_cnt_d = r_bubble_cnt_q;
        if (ex_flush) begin
            // Data fields are left as-is; only validity and controls matter.
            w_ex_d.valid = 1'b0;
            w_ex_d.ctrl  = '0;
        end else if (ex_stall) begin
            w_ex_d = r_ex_q;
        end else if (w_hazard) begin
            w_ex_d.valid = 1'b0;
            w_ex_d.ctrl  = '0;
            if (r_bubble_cnt_q != c_BUBBLE_MAX) begin
                w_bubble_cnt_d = r_bubble_cnt_q + 16'd1;
            end
        end else begin
            w_ex_d.valid    = id_valid;
            w_ex_d.pc       = id_pc;
            w_ex_d.rs1_data = id_rs1_data;
            w_ex_d.rs2_data = id_rs2_data;
            w_ex_d.imm      = id_imm;
            w_ex_d.rs1      = id_rs1;
            w_ex_d.rs2      = id_rs2;
            w_ex_d.rd       = id_rd;
            w_ex_d.funct3   = id_funct3;
            w_ex_d.funct7_5 = id_funct7_5;
            w_ex_d.ctrl     = id_valid ? w_id_ctrl : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_q         <= '0;
            r_bubble_cnt_q <= '0;
        end else begin
            r_ex_q         <= w_ex_d;
            r_bubble_cnt_q <= w_bubble_cnt_d;
        end
    end

    assign ex_valid     = r_ex_q.valid;
    assign ex_pc        = r_ex_q.pc;
    assign ex_rs1_data  = r_ex_q.rs1_data;
    assign ex_rs2_data  = r_ex_q.rs2_data;
    assign ex_imm       = r_ex_q.imm;
    assign ex_rs1       = r_ex_q.rs1;
    assign ex_rs2       = r_ex_q.rs2;
    assign ex_rd        = r_ex_q.rd;
    assign ex_funct3    = r_ex_q.funct3;
    assign ex_funct7_5  = r_ex_q.funct7_5;
    assign ex_branch    = r_ex_q.ctrl.branch;
    assign ex_memRead   = r_ex_q.ctrl.mem_read;
    assign ex_memtoReg  = r_ex_q.ctrl.memto_reg;
    assign ex_memWrite  = r_ex_q.ctrl.mem_write;
    assign ex_ALUSrc    = r_ex_q.ctrl.alu_src;
    assign ex_regWrite  = r_ex_q.ctrl.reg_write;
    assign ex_ALUOp     = r_ex_q.ctrl.alu_op;
    assign bubble_count = r_bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Directed plus random-vector self-checking bench for id_ex_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    // Control bundle packing: {branch, memRead, memtoReg, memWrite, ALUSrc, regWrite, ALUOp}
    localparam logic [7:0] c_ADD = 8'b0000_0110;
    localparam logic [7:0] c_LW  = 8'b0110_1100;
    localparam logic [7:0] c_SW  = 8'b0001_1000;
    localparam logic [7:0] c_LUI = 8'b0000_1100;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs1, id_uses_rs2;
    logic [2:0]  id_funct3;
    logic        id_funct7_5;
    logic        id_branch, id_memRead, id_memtoReg, id_memWrite, id_ALUSrc, id_regWrite;
    logic [1:0]  id_ALUOp;
    logic        ex_stall, ex_flush;
    logic        stall_id, ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_funct7_5;
    logic        ex_branch, ex_memRead, ex_memtoReg, ex_memWrite, ex_ALUSrc, ex_regWrite;
    logic [1:0]  ex_ALUOp;
    logic [15:0] bubble_count;

    id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
        .id_branch(id_branch), .id_memRead(id_memRead), .id_memtoReg(id_memtoReg),
        .id_memWrite(id_memWrite), .id_ALUSrc(id_ALUSrc), .id_regWrite(id_regWrite),
        .id_ALUOp(id_ALUOp), .ex_stall(ex_stall), .ex_flush(ex_flush),
        .stall_id(stall_id), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_funct7_5(ex_funct7_5),
        .ex_branch(ex_branch), .ex_memRead(ex_memRead), .ex_memtoReg(ex_memtoReg),
        .ex_memWrite(ex_memWrite), .ex_ALUSrc(ex_ALUSrc), .ex_regWrite(ex_regWrite),
        .ex_ALUOp(ex_ALUOp), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Reference model: what sits in EX, as plain variables.
    bit          m_valid;
    logic [7:0]  m_ctrl;
    int          m_cnt;
    bit          m_known;   // data fields are defined (not after flush/bubble)
    logic [31:0] m_pc, m_r1d, m_r2d, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [2:0]  m_f3;
    logic        m_f7;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic bit m_hazard();
        bit reads_rd;
        reads_rd = (id_uses_rs1 && id_rs1 == m_rd) || (id_uses_rs2 && id_rs2 == m_rd);
        return id_valid && m_valid && m_ctrl[6] && (m_rd != 5'd0) && reads_rd;
    endfunction

    function automatic logic [7:0] id_ctrl();
        return {id_branch, id_memRead, id_memtoReg, id_memWrite, id_ALUSrc, id_regWrite, id_ALUOp};
    endfunction

    task automatic model_step();
        if (rst) begin
            m_valid = 0; m_ctrl = '0; m_cnt = 0; m_known = 1;
            m_pc = '0; m_r1d = '0; m_r2d = '0; m_imm = '0;
            m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_f3 = '0; m_f7 = 1'b0;
        end else if (ex_flush) begin
            m_valid = 0; m_ctrl = '0; m_known = 0;
        end else if (ex_stall) begin
            m_valid = m_valid;
        end else if (m_hazard()) begin
            m_valid = 0; m_ctrl = '0; m_known = 0;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end else begin
            m_valid = id_valid;
            m_ctrl  = id_valid ? id_ctrl() : 8'h00;
            m_known = 1;
            m_pc = id_pc; m_r1d = id_rs1_data; m_r2d = id_rs2_data; m_imm = id_imm;
            m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_f3 = id_funct3; m_f7 = id_funct7_5;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall_id", {31'd0, stall_id}, {31'd0, !ex_flush && (m_hazard() || ex_stall)});
            chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
            chk("ex_ctrl", {24'd0, ex_branch, ex_memRead, ex_memtoReg, ex_memWrite,
                            ex_ALUSrc, ex_regWrite, ex_ALUOp}, {24'd0, m_ctrl});
            chk("bubble_count", {16'd0, bubble_count}, m_cnt);
            if (m_known) begin
                chk("ex_pc", ex_pc, m_pc);
                chk("ex_rs_data", ex_rs1_data ^ {ex_rs2_data[15:0], ex_rs2_data[31:16]},
                    m_r1d ^ {m_r2d[15:0], m_r2d[31:16]});
                chk("ex_imm", ex_imm, m_imm);
                chk("ex_idx", {12'd0, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7_5},
                    {12'd0, m_rs1, m_rs2, m_rd, m_f3, m_f7});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit v, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input bit u1, input bit u2,
                         input logic [7:0] ctrl, input logic [31:0] r1d);
        id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_uses_rs1 = u1; id_uses_rs2 = u2;
        {id_branch, id_memRead, id_memtoReg, id_memWrite, id_ALUSrc, id_regWrite, id_ALUOp} = ctrl;
        id_rs1_data = r1d;
        id_pc = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
        id_funct3 = 3'($urandom_range(0, 7)); id_funct7_5 = 1'($urandom_range(0, 1));
    endtask

    initial begin
        m_valid = 0; m_ctrl = '0; m_cnt = 0; m_known = 0;
        rst = 1'b1; ex_stall = 1'b0; ex_flush = 1'b0;
        drive(1, 5'd3, 5'd1, 5'd2, 1, 1, c_ADD, 32'hDEAD);
        // Reset held two cycles with a live instruction at the input.
        tick(); tick();
        chk_en = 1'b1;
        chk("rst ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst ex_regWrite", {31'd0, ex_regWrite}, 32'd0);
        chk("rst bubble_count", {16'd0, bubble_count}, 32'd0);
        chk("rst ex_rs1_data", ex_rs1_data, 32'd0);
        chk("rst ex_rd", {27'd0, ex_rd}, 32'd0);
        rst = 1'b0;

        // Pass-through R-type add x5, x1, x2.
        drive(1, 5'd5, 5'd1, 5'd2, 1, 1, c_ADD, 32'h11);
        #1 chk("pass stall_id pre", {31'd0, stall_id}, 32'd0);
        tick();
        chk("pass ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("pass ex_rd", {27'd0, ex_rd}, 32'd5);
        chk("pass ex_ALUOp", {30'd0, ex_ALUOp}, 32'd2);
        chk("pass ex_rs1_data", ex_rs1_data, 32'h11);
        chk("pass stall_id post", {31'd0, stall_id}, 32'd0);

        // Load-use: lw x5 then add x6, x5, x7.
        drive(1, 5'd5, 5'd1, 5'd0, 1, 0, c_LW, 32'h100);
        tick();
        drive(1, 5'd6, 5'd5, 5'd7, 1, 1, c_ADD, 32'h22);
        #1 chk("lu stall_id", {31'd0, stall_id}, 32'd1);
        tick();
        chk("lu bubble ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu bubble ex_memRead", {31'd0, ex_memRead}, 32'd0);
        chk("lu bubble_count", {16'd0, bubble_count}, 32'd1);
        chk("lu stall released", {31'd0, stall_id}, 32'd0);
        tick();
        chk("lu add ex_rd", {27'd0, ex_rd}, 32'd6);
        chk("lu add ex_valid", {31'd0, ex_valid}, 32'd1);

        // lw x0 followed by a reader of x0: no hazard.
        drive(1, 5'd0, 5'd1, 5'd0, 1, 0, c_LW, 32'h0);
        tick();
        drive(1, 5'd7, 5'd0, 5'd0, 1, 1, c_ADD, 32'h0);
        #1 chk("x0 stall_id", {31'd0, stall_id}, 32'd0);
        tick();

        // lw x5 followed by LUI whose unused rs1 field is 5.
        drive(1, 5'd5, 5'd1, 5'd0, 1, 0, c_LW, 32'h200);
        tick();
        drive(1, 5'd8, 5'd5, 5'd0, 0, 0, c_LUI, 32'h0);
        #1 chk("lui stall_id", {31'd0, stall_id}, 32'd0);
        tick();
        chk("lui bubble_count", {16'd0, bubble_count}, 32'd1);
        chk("lui ex_rd", {27'd0, ex_rd}, 32'd8);

        // Flush coinciding with a load-use hazard.
        drive(1, 5'd5, 5'd1, 5'd0, 1, 0, c_LW, 32'h300);
        tick();
        drive(1, 5'd6, 5'd5, 5'd0, 1, 0, c_ADD, 32'h0);
        ex_flush = 1'b1;
        #1 chk("flush stall_id", {31'd0, stall_id}, 32'd0);
        tick();
        ex_flush = 1'b0;
        chk("flush ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("flush ex_ctrl", {24'd0, ex_branch, ex_memRead, ex_memtoReg, ex_memWrite,
                              ex_ALUSrc, ex_regWrite, ex_ALUOp}, 32'd0);
        chk("flush bubble_count", {16'd0, bubble_count}, 32'd1);

        // Store held in EX by a three-cycle downstream stall.
        drive(1, 5'd0, 5'd2, 5'd3, 1, 1, c_SW, 32'h400);
        tick();
        drive(1, 5'd9, 5'd1, 5'd2, 1, 1, c_ADD, 32'h55);
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall stall_id", {31'd0, stall_id}, 32'd1);
            tick();
            chk("stall ex_memWrite", {31'd0, ex_memWrite}, 32'd1);
        end
        ex_stall = 1'b0;
        tick();
        chk("stall release ex_rd", {27'd0, ex_rd}, 32'd9);
        chk("stall release ex_memWrite", {31'd0, ex_memWrite}, 32'd0);

        // Stall and hazard together: hold wins, bubble follows the release.
        drive(1, 5'd4, 5'd1, 5'd0, 1, 0, c_LW, 32'h500);
        tick();
        drive(1, 5'd6, 5'd0, 5'd4, 0, 1, c_ADD, 32'h0);
        ex_stall = 1'b1;
        tick();
        chk("stall+hz bubble_count", {16'd0, bubble_count}, 32'd1);
        chk("stall+hz ex_memRead", {31'd0, ex_memRead}, 32'd1);
        ex_stall = 1'b0;
        tick();
        chk("post-stall bubble_count", {16'd0, bubble_count}, 32'd2);
        tick();
        chk("post-stall ex_rd", {27'd0, ex_rd}, 32'd6);

        // Reset asserted mid-hazard clears everything.
        drive(1, 5'd5, 5'd1, 5'd0, 1, 0, c_LW, 32'h600);
        tick();
        drive(1, 5'd6, 5'd5, 5'd0, 1, 0, c_ADD, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid-hz rst bubble_count", {16'd0, bubble_count}, 32'd0);
        chk("mid-hz rst ex_valid", {31'd0, ex_valid}, 32'd0);

        // Invalid ID slots carry no control bits into EX.
        drive(0, 5'd3, 5'd1, 5'd2, 1, 1, 8'hFF, 32'h7);
        tick();
        chk("idle ex_regWrite", {31'd0, ex_regWrite}, 32'd0);
        chk("idle ex_memWrite", {31'd0, ex_memWrite}, 32'd0);

        // Random traffic over a small register set, checked by the model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom), $urandom);
            if ($urandom_range(0, 2) == 0) {id_memRead, id_memWrite} = 2'b10;
            ex_flush = ($urandom_range(0, 9) == 0);
            ex_stall = ($urandom_range(0, 5) == 0);
            rst      = ($urandom_range(0, 59) == 0);
            tick();
        end
        rst = 1'b0; ex_flush = 1'b0; ex_stall = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
